multicycle_controller: RTL
==========================

# multicycle_controller

Sequencing FSM for the multicycle RV32I core datapath, where one shared memory port serves instruction fetch and load/store. Decodes opcode/funct fields from the instruction register and drives per-state mux selects, write enables and ALU control, one micro-step per clock. Stretches memory states on a ready handshake and flags instruction retirement.

## Interface
- HAS_MEM_READY, 1: 1 = honour `mem_ready`; 0 = tie internally to 1 (single-cycle memory).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
- PCWrite  out  1  PC register load
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- MemWrite  out  1  memory store enable
- IRWrite  out  1  instruction/OldPC register load
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2/WriteData, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal  out  1  sticky illegal-opcode flag (only with macro, else constant 0)

## Operation
- Moore FSM; all outputs combinational from state, plus `op`/funct/Zero/mem_ready where noted. Unlisted outputs 0.
- FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10. IRWrite and PCWrite asserted only when mem_ready; → DECODE on mem_ready, else hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next by op: 0000011/0100011 → MEMADR, 0110011 → EXECUTER, 0010011 → EXECUTEI, 1100011 → BEQ, 1101111 → JAL, other → illegal handling.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0 → MEMREAD, 1 → MEMWRITE.
- MEMREAD: mem_req, AdrSrc=1; → MEMWB on mem_ready, else hold.
- MEMWB: ResultSrc=01, RegWrite, instr_done; → FETCH.
- MEMWRITE: mem_req, AdrSrc=1, MemWrite held high until mem_ready; instr_done on the ready cycle; → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp funct; EXECUTEI: ALUSrcB=01, ALUOp funct; both → ALUWB.
- ALUWB: ResultSrc=00, RegWrite, instr_done; → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, instr_done; → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; → ALUWB (writes PC+4 to rd).
- ALU decode for ALUOp funct: funct3 000 → sub iff op[5]&funct7b5 else add; 010 → slt; 110 → or; 111 → and; other → add.
- ImmSrc decoded from op in every state: I for 0000011/0010011, S for 0100011, B for 1100011, J for 1101111, else 00.

## Timing
- Reset: state=FETCH asynchronously; illegal=0; outputs take FETCH decode (IRWrite/PCWrite gated by mem_ready).
- Cycles with mem_ready=1 always: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds one.
- mem_ready is sampled only in FETCH/MEMREAD/MEMWRITE; ignored elsewhere.
- mem_req and address select stable while waiting; no requests abandoned except by reset.
- Reset mid-instruction: immediate return to FETCH, no pending write completes after deassertion.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: undecodable op in DECODE → HALT state; all enables 0, mem_req 0, illegal=1 sticky; exit only by reset.
- Undefined: undecodable op in DECODE → FETCH treated as NOP (instr_done pulsed in DECODE); illegal tied 0; no HALT state.

## Structure
- Package mc_pkg: state encoding constants, ALUOp codes (add/sub/funct), ALUControl codes, opcode constants, ResultSrc/ALUSrc select codes.
- Sub-module alu_decoder: (ALUOp, funct3, funct7b5, op[5]) → ALUControl, purely combinational.

## Test plan
- Reset asserted in MEMWRITE with mem_ready=0 → MemWrite drops to 0 asynchronously, state FETCH, illegal=0.
- lw (op=0000011), mem_ready=1 → FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite and ResultSrc=01 only in cycle 5, instr_done single pulse.
- sw with mem_ready low 2 cycles in MEMWRITE → MemWrite high 3 cycles, AdrSrc=1 stable, then FETCH.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER; addi with funct7b5=1 → 000.
- beq with Zero=1 → PCWrite=1 in BEQ; Zero=0 → PCWrite=0; both 3 cycles.
- op=1111111 → with MC_ILLEGAL_TRAP_EN: HALT, illegal=1, no further mem_req; without: back to FETCH, instr_done pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I controller: state encoding,
// ALUOp/ALUControl codes, opcodes, datapath select codes and the
// immediate-format decode helper.
package mc_pkg;

    localparam int unsigned OP_W       = 7;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned ALU_CTRL_W = 3;

    // Controller states; S_HALT is reachable only when the illegal trap is built in.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // ALUOp: what the controller asks of the ALU decoder
    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes seen by the datapath ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    // ResultSrc
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's ALUOp plus instruction funct fields to
// the 3-bit ALUControl code. Purely combinational.
// Ports: alu_op (ALUOp), funct3, funct7b5, op5 (Instr[5]) -> alu_control.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  op5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; addi with that bit set stays add
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: Moore FSM sequencing fetch/decode/execute over
// a single shared memory port, with memory states stretched by mem_ready.
// Config macro: MC_ILLEGAL_TRAP_EN - undecodable opcodes trap into a HALT
//   state with a sticky illegal flag; otherwise they retire as NOPs.
// Parameter: HAS_MEM_READY - 1 honours mem_ready, 0 treats memory as single-cycle.
// Ports: clk, rst (async, active-high); op, funct3, funct7b5, Zero, mem_ready in;
//   mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite, instr_done, illegal out (combinational from state).
module multicycle_controller
    import mc_pkg::*;
#(
    parameter bit HAS_MEM_READY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [SEL_W-1:0]      ResultSrc,
    output logic [SEL_W-1:0]      ALUSrcA,
    output logic [SEL_W-1:0]      ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [SEL_W-1:0]      ImmSrc,
    output logic                  RegWrite,
    output logic                  instr_done,
    output logic                  illegal
);

    state_t               state;
    state_t               state_next;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 ready;

    assign ready = HAS_MEM_READY ? mem_ready : 1'b1;

`ifndef MC_ILLEGAL_TRAP_EN
    logic op_legal;
    assign op_legal = (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
                      (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_next = S_HALT;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:     state_next = S_HALT;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode per state
    always_comb begin
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        ImmSrc     = imm_src_of(op);
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
`ifndef MC_ILLEGAL_TRAP_EN
                // unknown opcode retires here as a NOP
                instr_done = ~op_legal;
`endif
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = ready;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                PCWrite    = Zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    // HALT is left only through reset, so the state itself is the sticky flag
    assign illegal = (state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule
